// File: rtl/teclado_pkg.sv
// teclado_pkg: shared types and helpers for the keypad scan front-end.
// Holds the debounce FSM state enum, the empty-code constant and the
// index-to-code mapping used when a debounced press is queued.
package teclado_pkg;

    // State | meaning
    // IDLE      | no key held, waiting for any synchronised key line
    // DEB_PRESS | a key was selected, counting stable high samples
    // HELD      | press accepted and queued, waiting for all keys low
    // DEB_REL   | all keys low, counting stable low samples
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DEB_PRESS = 2'd1,
        HELD      = 2'd2,
        DEB_REL   = 2'd3
    } teclado_state_e;

    localparam int CODE_NONE  = 0;
    localparam int MAX_CODE_W = 4;   // 15 keys -> codes 1..15
    localparam int CNT_W      = 8;   // debounce length up to 255

    // Code 0 is reserved for "nothing queued", so key i maps to i+1.
    function automatic logic [MAX_CODE_W-1:0] code_from_index(
        input logic [MAX_CODE_W-1:0] idx
    );
        return idx + MAX_CODE_W'(1);
    endfunction

endpackage

// File: rtl/teclado_scan_fifo_if.sv
// teclado_scan_fifo_if: key-code delivery bus between the keypad front-end
// (master) and the access-control consumer (slave).
interface teclado_scan_fifo_if #(
    parameter int CODE_W = 3
);
    logic [CODE_W-1:0] key_code;
    logic              key_valid;
    logic              key_ready;
    logic              key_done;
    logic              overflow;
    logic              ovf_clr;

    modport master (
        output key_code,
        output key_valid,
        output key_done,
        output overflow,
        input  key_ready,
        input  ovf_clr
    );

    modport slave (
        input  key_code,
        input  key_valid,
        input  key_done,
        input  overflow,
        output key_ready,
        output ovf_clr
    );
endinterface

// File: rtl/teclado_code_fifo.sv
// teclado_code_fifo: key-code queue with registered head (code + valid).
// Build option TECLADO_FIFO_EN selects a circular FIFO of FIFO_DEPTH
// entries; without it a single holding register is used. In both builds a
// pop frees its slot on the same edge, so a push into a full queue that is
// being popped is accepted. o_drop flags a push that found no room.
module teclado_code_fifo
    import teclado_pkg::*;
#(
    parameter int CODE_W     = 3,
    parameter int FIFO_DEPTH = 4
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic [CODE_W-1:0] i_push_code,
    input  logic              i_ready,
    output logic [CODE_W-1:0] o_code,
    output logic              o_valid,
    output logic              o_drop
);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
        $error("teclado_code_fifo: FIFO_DEPTH must be a power of two >= 2");
    end

    logic [CODE_W-1:0] r_code;
    logic              r_valid;
    logic              w_pop;
    logic              w_accept;

`ifdef TECLADO_FIFO_EN
    localparam int              PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    logic [CODE_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W:0]    r_count;

    logic [PTR_W:0]    w_occ;
    logic [PTR_W:0]    w_count_nx;
    logic [PTR_W-1:0]  w_rd_nx;
    logic [CODE_W-1:0] w_head_nx;

    // Pop first, then push; the head register is preloaded with whatever
    // entry will be at the front after this edge.
    always_comb begin
        w_pop      = r_valid && i_ready;
        w_accept   = i_push && ((r_count != FULL_CNT) || w_pop);
        w_occ      = r_count - (PTR_W + 1)'(w_pop);
        w_count_nx = w_occ + (PTR_W + 1)'(w_accept);
        w_rd_nx    = w_pop ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;
        if (w_count_nx == '0) begin
            w_head_nx = CODE_W'(CODE_NONE);
        end else if (w_occ == '0) begin
            w_head_nx = i_push_code;
        end else begin
            w_head_nx = r_mem[w_rd_nx];
        end
    end

    // Pointer, occupancy and registered head update.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
            r_code   <= CODE_W'(CODE_NONE);
        end else begin
            r_rd_ptr <= w_rd_nx;
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            r_count <= w_count_nx;
            r_valid <= (w_count_nx != '0);
            r_code  <= w_head_nx;
        end
    end

    // Storage write; contents are don't-care until counted as occupied.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= i_push_code;
        end
    end
`else
    // Single slot: accept when empty or being emptied on this edge.
    always_comb begin
        w_pop    = r_valid && i_ready;
        w_accept = i_push && (!r_valid || w_pop);
    end

    // Holding register update.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_code  <= CODE_W'(CODE_NONE);
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_code  <= i_push_code;
        end else if (w_pop) begin
            r_valid <= 1'b0;
            r_code  <= CODE_W'(CODE_NONE);
        end
    end
`endif

    assign o_code  = r_code;
    assign o_valid = r_valid;
    assign o_drop  = i_push && !w_accept;

endmodule

// File: rtl/teclado_scan_fifo.sv
// teclado_scan_fifo: keypad front-end. Synchronises N_KEYS raw lines,
// debounces press and release, picks the lowest-index key and queues its
// code (index+1) for a valid/ready consumer. One code per physical press.
// Build option TECLADO_FIFO_EN: multi-entry code FIFO instead of a single
// holding register (see teclado_code_fifo).
module teclado_scan_fifo
    import teclado_pkg::*;
#(
    parameter int N_KEYS     = 4,
    parameter int DEB_CYCLES = 4,
    parameter int FIFO_DEPTH = 4
)(
    input  logic                clk,
    input  logic                reset,
    input  logic [N_KEYS-1:0]   keys_in,
    teclado_scan_fifo_if.master bus
);

    localparam int              CODE_W = $clog2(N_KEYS + 1);
    localparam logic [CNT_W-1:0] DEB_TC = CNT_W'(DEB_CYCLES);

    if (N_KEYS < 2 || N_KEYS > 15 || DEB_CYCLES < 1 || DEB_CYCLES > 255) begin : g_param_check
        $error("teclado_scan_fifo: N_KEYS must be 2..15 and DEB_CYCLES 1..255");
    end

    logic [N_KEYS-1:0] r_sync1;
    logic [N_KEYS-1:0] r_ks;
    teclado_state_e    r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [CODE_W-1:0] r_sel;
    logic              r_done;
    logic              r_ovf;

    teclado_state_e    w_state_nx;
    logic [CNT_W-1:0]  w_cnt_nx;
    logic [CODE_W-1:0] w_sel_nx;
    logic              w_push;
    logic              w_any;
    logic [CODE_W-1:0] w_low_idx;
    logic              w_sel_bit;
    logic [CODE_W-1:0] w_push_code;
    logic [CODE_W-1:0] w_code;
    logic              w_valid;
    logic              w_drop;

    // Two-flop synchroniser for the asynchronous key lines.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_ks    <= '0;
        end else begin
            r_sync1 <= keys_in;
            r_ks    <= r_sync1;
        end
    end

    // Priority encoder: lowest set index wins.
    always_comb begin
        w_any     = 1'b0;
        w_low_idx = '0;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (r_ks[i]) begin
                w_any     = 1'b1;
                w_low_idx = CODE_W'(i);
            end
        end
    end

    assign w_sel_bit   = |(r_ks & (N_KEYS'(1) << r_sel));
    assign w_push_code = CODE_W'(code_from_index(MAX_CODE_W'(r_sel)));

    // Debounce FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_sel   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_sel   <= w_sel_nx;
        end
    end

    // Debounce FSM next state; only the selected key matters during the
    // press debounce, any key restarts the release debounce.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_sel_nx   = r_sel;
        w_push     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_sel_nx   = w_low_idx;
                    w_cnt_nx   = CNT_W'(1);
                    w_state_nx = DEB_PRESS;
                end
            end
            DEB_PRESS: begin
                if (!w_sel_bit) begin
                    w_state_nx = IDLE;
                end else if (r_cnt == DEB_TC) begin
                    w_push     = 1'b1;
                    w_state_nx = HELD;
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            HELD: begin
                if (!w_any) begin
                    w_cnt_nx   = CNT_W'(1);
                    w_state_nx = DEB_REL;
                end
            end
            DEB_REL: begin
                if (w_any) begin
                    w_state_nx = HELD;
                end else if (r_cnt == DEB_TC) begin
                    w_state_nx = IDLE;
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    teclado_code_fifo #(
        .CODE_W     (CODE_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_code_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_code (w_push_code),
        .i_ready     (bus.key_ready),
        .o_code      (w_code),
        .o_valid     (w_valid),
        .o_drop      (w_drop)
    );

    // Accept pulse and sticky overflow; a new drop beats a clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_done <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_done <= w_push;
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (bus.ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign bus.key_code  = w_code;
    assign bus.key_valid = w_valid;
    assign bus.key_done  = r_done;
    assign bus.overflow  = r_ovf;

endmodule

// File: tb/tb_teclado_scan_fifo.sv
// Bench for teclado_scan_fifo: directed scenarios followed by random key
// activity, each edge compared against a press/queue reference model.
module tb_teclado_scan_fifo;
    localparam int N_KEYS     = 4;
    localparam int DEB_CYCLES = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int CODE_W     = $clog2(N_KEYS + 1);
`ifdef TECLADO_FIFO_EN
    localparam int Q_CAP = FIFO_DEPTH;
`else
    localparam int Q_CAP = 1;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [N_KEYS-1:0] keys_in;

    teclado_scan_fifo_if #(.CODE_W(CODE_W)) bus();

    teclado_scan_fifo #(
        .N_KEYS     (N_KEYS),
        .DEB_CYCLES (DEB_CYCLES),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .keys_in (keys_in),
        .bus     (bus.master)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: keys seen two edges late; a press is one key held for
    // DEB_CYCLES+1 consecutive samples from the first sample where any key
    // appeared; after a press, DEB_CYCLES+1 all-low samples rearm.
    logic [N_KEYS-1:0] m_d1, m_d2;
    int  m_cand, m_run, m_quiet;
    bit  m_latched, m_ovf, m_done;
    int  m_q[$];

    function automatic int lowest_key(input logic [N_KEYS-1:0] v);
        for (int i = 0; i < N_KEYS; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_edge();
        logic [N_KEYS-1:0] s;
        bit push_req, drop;
        int code;
        s = m_d2; push_req = 0; drop = 0; code = 0;
        if (reset) begin
            m_d1 = '0; m_d2 = '0; m_cand = -1; m_run = 0; m_quiet = 0;
            m_latched = 0; m_ovf = 0; m_done = 0; m_q.delete();
            return;
        end
        if (m_latched) begin
            if (s == '0) begin
                m_quiet++;
                if (m_quiet == DEB_CYCLES + 1) m_latched = 0;
            end else begin
                m_quiet = 0;
            end
        end else if (m_cand < 0) begin
            if (s != '0) begin m_cand = lowest_key(s); m_run = 1; end
        end else if (!s[m_cand]) begin
            m_cand = -1;
        end else begin
            m_run++;
            if (m_run == DEB_CYCLES + 1) begin
                push_req = 1; code = m_cand + 1;
                m_latched = 1; m_quiet = 0; m_cand = -1;
            end
        end
        if (m_q.size() > 0 && bus.key_ready) void'(m_q.pop_front());
        if (push_req) begin
            if (m_q.size() < Q_CAP) m_q.push_back(code);
            else drop = 1;
        end
        m_done = push_req;
        if (drop) m_ovf = 1;
        else if (bus.ovf_clr) m_ovf = 0;
        m_d2 = m_d1;
        m_d1 = keys_in;
    endtask

    task automatic compare_all();
        int exp_code;
        exp_code = (m_q.size() > 0) ? m_q[0] : 0;
        check_eq("key_valid", bus.key_valid, (m_q.size() > 0));
        check_eq("key_code", bus.key_code, exp_code);
        check_eq("key_done", bus.key_done, m_done);
        check_eq("overflow", bus.overflow, m_ovf);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic press(input logic [N_KEYS-1:0] mask);
        keys_in = mask;
        repeat (DEB_CYCLES + 4) step();
        keys_in = '0;
        repeat (DEB_CYCLES + 4) step();
    endtask

    int first_done, n_done;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; keys_in = '0; bus.key_ready = 1'b0; bus.ovf_clr = 1'b0;
        m_cand = -1;
        repeat (3) step();
        reset = 1'b0;

        // Held key 2: code 3 after edge DEB_CYCLES+2, exactly once.
        bus.key_ready = 1'b1;
        keys_in = 4'b0100;
        first_done = -1; n_done = 0;
        for (int e = 0; e < 20; e++) begin
            step();
            if (bus.key_done) begin
                n_done++;
                if (first_done < 0) begin
                    first_done = e;
                    check_eq("first_code", bus.key_code, 3);
                end
            end
        end
        check_eq("latency_edge", first_done, DEB_CYCLES + 2);
        check_eq("one_code", n_done, 1);
        keys_in = '0;
        repeat (DEB_CYCLES + 4) step();

        // Glitch shorter than the debounce window.
        keys_in = 4'b0001; n_done = 0;
        repeat (3) step();
        keys_in = '0;
        for (int e = 0; e < 12; e++) begin step(); if (bus.key_done) n_done++; end
        check_eq("glitch_done", n_done, 0);

        // Two keys: lowest wins, partial release yields nothing new.
        keys_in = 4'b1010; n_done = 0;
        for (int e = 0; e < 10; e++) begin step(); if (bus.key_done) n_done++; end
        keys_in = 4'b1000;
        for (int e = 0; e < 10; e++) begin step(); if (bus.key_done) n_done++; end
        keys_in = '0;
        for (int e = 0; e < 10; e++) begin step(); if (bus.key_done) n_done++; end
        check_eq("multi_done", n_done, 1);

        // Fill with consumer stalled, one extra press overflows.
        bus.key_ready = 1'b0;
        repeat (Q_CAP + 1) press(4'b0001);
        check_eq("ovf_after_fill", bus.overflow, 1);
        bus.ovf_clr = 1'b1; step(); bus.ovf_clr = 1'b0;
        check_eq("ovf_cleared", bus.overflow, 0);

        // Full queue popped on the push edge: push accepted, no overflow.
        keys_in = 4'b0010;
        repeat (DEB_CYCLES + 2) step();
        bus.key_ready = 1'b1;
        step();
        bus.key_ready = 1'b0;
        check_eq("pop_push_ovf", bus.overflow, 0);
        keys_in = '0;
        repeat (DEB_CYCLES + 4) step();

        // Drop coinciding with ovf_clr: the set wins.
        keys_in = 4'b0100;
        repeat (DEB_CYCLES + 2) step();
        bus.ovf_clr = 1'b1;
        step();
        bus.ovf_clr = 1'b0;
        check_eq("ovf_set_wins", bus.overflow, 1);
        keys_in = '0;
        repeat (DEB_CYCLES + 4) step();

        bus.key_ready = 1'b1;
        repeat (Q_CAP + 3) step();

        // Reset with codes queued and a press mid-debounce.
        bus.key_ready = 1'b0;
        press(4'b0001);
        press(4'b0010);
        keys_in = 4'b0100;
        repeat (4) step();
        reset = 1'b1; keys_in = '0;
        step();
        reset = 1'b0;
        check_eq("rst_valid", bus.key_valid, 0);
        check_eq("rst_ovf", bus.overflow, 0);
        repeat (12) step();
        bus.key_ready = 1'b1;
        repeat (4) step();

        // Random key activity, consumer stalls, clears and rare resets.
        for (int k = 0; k < 150; k++) begin
            int hold;
            keys_in = N_KEYS'($urandom_range(0, (1 << N_KEYS) - 1));
            if ($urandom_range(0, 3) == 0) keys_in = '0;
            hold = $urandom_range(1, 2 * DEB_CYCLES + 6);
            for (int c = 0; c < hold; c++) begin
                bus.key_ready = ($urandom_range(0, 3) != 0);
                bus.ovf_clr   = ($urandom_range(0, 15) == 0);
                reset         = ($urandom_range(0, 299) == 0);
                step();
            end
        end
        reset = 1'b0; bus.ovf_clr = 1'b0; keys_in = '0; bus.key_ready = 1'b1;
        repeat (DEB_CYCLES + Q_CAP + 6) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
